// File: rtl/alu_issue_unit_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_unit_pkg
//   Shared definitions for the ALU issue unit: instruction field positions,
//   legal function codes, FSM state encoding and a legality helper.
// ---------------------------------------------------------------------------
package alu_issue_unit_pkg;

  localparam int INSTR_W = 32;
  localparam int REG_AW  = 5;
  localparam int SHAMT_W = 5;
  localparam int FUNCT_W = 6;
  localparam int OP_W    = 6;

  // Instruction field bit positions
  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  localparam logic [OP_W-1:0]    OP_RTYPE   = 6'b000000;
  localparam logic [FUNCT_W-1:0] FUNCT_ADDU = 6'b001001;
  localparam logic [FUNCT_W-1:0] FUNCT_SUBU = 6'b001010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND  = 6'b010001;
  localparam logic [FUNCT_W-1:0] FUNCT_SLL  = 6'b100001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Only R-type words carrying one of the four supported funct codes are legal.
  function automatic logic is_legal(input logic [INSTR_W-1:0] w);
    logic [FUNCT_W-1:0] fn;
    fn = w[FUNCT_MSB:FUNCT_LSB];
    return (w[OP_MSB:OP_LSB] == OP_RTYPE) &&
           ((fn == FUNCT_ADDU) || (fn == FUNCT_SUBU) ||
            (fn == FUNCT_AND)  || (fn == FUNCT_SLL));
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// ---------------------------------------------------------------------------
// alu_regfile
//   NREG x XLEN register file: two asynchronous read ports, one asynchronous
//   debug read port, one synchronous write port. Register 0 is hardwired to
//   zero (writes ignored, reads return 0). Async active-low clear.
// Ports
//   clk, rst_n        clock / async active-low clear of every entry
//   raddr1/rdata1     operand read port 1 (combinational)
//   raddr2/rdata2     operand read port 2 (combinational)
//   dbg_addr/dbg_data debug read port (combinational)
//   we/waddr/wdata    write port, takes effect at the rising edge
// ---------------------------------------------------------------------------
module alu_regfile #(
  parameter int NREG = 32,
  parameter int XLEN = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata2,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Entry 0 is never written, but masking the read keeps r0 == 0 explicit.
  assign rdata1   = (raddr1   == '0) ? '0 : regs[raddr1];
  assign rdata2   = (raddr2   == '0) ? '0 : regs[raddr2];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// ---------------------------------------------------------------------------
// alu_issue_unit
//   Issue side of the ALU interface. Accepts one R-type instruction word per
//   four cycles over valid/ready, reads rs/rt from the internal register file,
//   presents operands to an external combinational ALU, captures the result
//   and writes it back to rd.
//   Sequence: IDLE (accept) -> READ (load operands) -> EXEC (capture result)
//             -> WB (pulse wb_valid or illegal, write rd at the closing edge).
// Ports
//   clk, rst_n           clock, async active-low reset
//   instr_valid/ready    instruction handshake (ready only in IDLE)
//   instr                op|rs|rt|rd|shamt|funct
//   alu_src1/src2        operands RF[rs]/RF[rt], held until the next op
//   alu_shamt/alu_funct  shift amount / function code to the ALU
//   alu_result           combinational ALU result
//   wb_valid/addr/data   one-cycle write-back report
//   illegal              one-cycle pulse for rejected instructions
//   dbg_addr/dbg_data    debug read of the register file
// ---------------------------------------------------------------------------
module alu_issue_unit
  import alu_issue_unit_pkg::*;
#(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] alu_src1,
  output logic [XLEN-1:0] alu_src2,
  output logic [4:0]      alu_shamt,
  output logic [5:0]      alu_funct,
  input  logic [XLEN-1:0] alu_result,
  output logic            wb_valid,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  state_t              state_q, state_d;
  logic [INSTR_W-1:0]  instr_p0;
  logic [REG_AW-1:0]   rs, rt, rd;
  logic [XLEN-1:0]     rf_rdata1, rf_rdata2;
  logic                legal;
  logic                rf_we;

  assign rs    = instr_p0[RS_MSB:RS_LSB];
  assign rt    = instr_p0[RT_MSB:RT_LSB];
  assign rd    = instr_p0[RD_MSB:RD_LSB];
  assign legal = is_legal(instr_p0);

  assign wb_addr = rd;

  alu_regfile #(
    .NREG (NREG),
    .XLEN (XLEN),
    .AW   (REG_AW)
  ) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr1   (rs),
    .rdata1   (rf_rdata1),
    .raddr2   (rt),
    .rdata2   (rf_rdata2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (rf_we),
    .waddr    (rd),
    .wdata    (wb_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    wb_valid    = 1'b0;
    illegal     = 1'b0;
    rf_we       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = ST_READ;
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        // rd == 0 still reports wb_valid; the regfile drops the write itself.
        wb_valid = legal;
        illegal  = ~legal;
        rf_we    = legal;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_p0  <= '0;
      alu_src1  <= '0;
      alu_src2  <= '0;
      alu_shamt <= '0;
      alu_funct <= '0;
      wb_data   <= '0;
    end else begin
      // IDLE -> READ: latch the accepted word
      if (state_q == ST_IDLE && instr_valid) instr_p0 <= instr;
      // READ -> EXEC: operands to the ALU; they stay put after the op
      if (state_q == ST_READ) begin
        alu_src1  <= rf_rdata1;
        alu_src2  <= rf_rdata2;
        alu_shamt <= instr_p0[SHAMT_MSB:SHAMT_LSB];
        alu_funct <= instr_p0[FUNCT_MSB:FUNCT_LSB];
      end
      // EXEC -> WB: capture the combinational ALU result
      if (state_q == ST_EXEC) wb_data <= alu_result;
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;

  localparam logic [5:0] F_ADDU = 6'b001001;
  localparam logic [5:0] F_SUBU = 6'b001010;
  localparam logic [5:0] F_AND  = 6'b010001;
  localparam logic [5:0] F_SLL  = 6'b100001;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] alu_src1, alu_src2;
  logic [4:0]  alu_shamt;
  logic [5:0]  alu_funct;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  // Reference ALU plus an override used to preload registers through ADDU.
  logic        alu_ovr_en;
  logic [31:0] alu_ovr_val;
  logic [31:0] alu_model;

  typedef struct {
    bit          wb;
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          acc_q[$];
  logic [31:0] exp_rf [32];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          ok;

  alu_issue_unit #(.NREG(32), .XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_src1    (alu_src1),
    .alu_src2    (alu_src2),
    .alu_shamt   (alu_shamt),
    .alu_funct   (alu_funct),
    .alu_result  (alu_result),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .illegal     (illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    alu_model = '0;
    case (alu_funct)
      F_ADDU:  alu_model = alu_src1 + alu_src2;
      F_SUBU:  alu_model = alu_src1 - alu_src2;
      F_AND:   alu_model = alu_src1 & alu_src2;
      F_SLL:   alu_model = alu_src1 << alu_shamt;
      default: alu_model = '0;
    endcase
    alu_result = alu_ovr_en ? alu_ovr_val : alu_model;
  end

  // Monitor: every wb_valid / illegal pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (wb_valid || illegal)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: wb_valid=%0b illegal=%0b addr=%0d data=%h, required no output",
                 wb_valid, illegal, wb_addr, wb_data);
      end else begin
        e  = q.pop_front();
        ok = (wb_valid == e.wb) && (illegal == !e.wb) && (cyc == e.cyc) &&
             (!e.wb || ((wb_addr == e.addr) && (wb_data == e.data)));
        if (!ok) begin
          errors++;
          $display("FAIL writeback: got wb=%0b ill=%0b addr=%0d data=%h cyc=%0d, required wb=%0b ill=%0b addr=%0d data=%h cyc=%0d",
                   wb_valid, illegal, wb_addr, wb_data, cyc, e.wb, !e.wb, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic issue(input logic [31:0] w, input bit push, input bit ewb,
                       input logic [4:0] eaddr, input logic [31:0] edata, input bit hold);
    bit done;
    done        = 1'b0;
    instr       = w;
    instr_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      if (instr_ready) begin
        if (push) q.push_back('{ewb, eaddr, edata, cyc + 3});
        acc_q.push_back(cyc + 1);
        done = 1'b1;
        @(posedge clk);
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: instr_ready=%0b, required 1 within 20 cycles", instr_ready);
    end
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [31:0] w, input bit ewb, input logic [4:0] eaddr,
                     input logic [31:0] edata);
    issue(w, 1'b1, ewb, eaddr, edata, 1'b0);
    drain();
    if (ewb && eaddr != 5'd0) exp_rf[eaddr] = edata;
  endtask

  task automatic preload(input logic [4:0] rd, input logic [31:0] val);
    alu_ovr_en  = 1'b1;
    alu_ovr_val = val;
    run(mk(6'd0, 5'd0, 5'd0, rd, 5'd0, F_ADDU), 1'b1, rd, val);
    alu_ovr_en  = 1'b0;
  endtask

  task automatic check_rf();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      check_eq($sformatf("dbg_r%0d", i), dbg_data, exp_rf[i]);
    end
    dbg_addr = 5'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    dbg_addr    = '0;
    alu_ovr_en  = 1'b0;
    alu_ovr_val = '0;
    for (int i = 0; i < 32; i++) exp_rf[i] = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_instr_ready", 32'(instr_ready), 32'd1);
    check_eq("rst_wb_valid",    32'(wb_valid),    32'd0);
    check_eq("rst_illegal",     32'(illegal),     32'd0);
    check_eq("rst_wb_addr",     32'(wb_addr),     32'd0);
    check_eq("rst_wb_data",     wb_data,          32'd0);
    check_eq("rst_alu_src1",    alu_src1,         32'd0);
    check_eq("rst_alu_src2",    alu_src2,         32'd0);
    check_eq("rst_alu_shamt",   32'(alu_shamt),   32'd0);
    check_eq("rst_alu_funct",   32'(alu_funct),   32'd0);
    check_rf();
    rst_n = 1'b1;
    @(negedge clk);

    // 1: r1=0, r2=10; ADDU r3 = r1 + r2
    preload(5'd2, 32'd10);
    run(mk(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, F_ADDU), 1'b1, 5'd3, 32'h0000000A);
    dbg_addr = 5'd3; #1;
    check_eq("dbg_r3_addu", dbg_data, 32'h0000000A);

    // 2: SUBU, normal and wrapping
    preload(5'd1, 32'd10);
    preload(5'd7, 32'd5);
    run(mk(6'd0, 5'd1, 5'd7, 5'd4, 5'd0, F_SUBU), 1'b1, 5'd4, 32'h00000005);
    run(mk(6'd0, 5'd7, 5'd1, 5'd8, 5'd0, F_SUBU), 1'b1, 5'd8, 32'hFFFFFFFB);

    // 3: AND 7 & 14, SLL 10 << 5
    preload(5'd9,  32'd7);
    preload(5'd10, 32'd14);
    run(mk(6'd0, 5'd9, 5'd10, 5'd5, 5'd0, F_AND), 1'b1, 5'd5, 32'h00000006);
    run(mk(6'd0, 5'd1, 5'd0,  5'd6, 5'd5, F_SLL), 1'b1, 5'd6, 32'h00000140);
    check_eq("alu_shamt_held", 32'(alu_shamt), 32'd5);
    check_eq("alu_funct_held", 32'(alu_funct), 32'(F_SLL));

    // 4: illegal funct, illegal opcode; RF must not change
    run(mk(6'd0, 5'd1, 5'd2, 5'd11, 5'd0, 6'b000000), 1'b0, 5'd0, 32'd0);
    run(mk(6'b000010, 5'd1, 5'd2, 5'd12, 5'd0, F_ADDU), 1'b0, 5'd0, 32'd0);
    check_rf();

    // 5: rd=0 still reports, r0 stays 0
    run(mk(6'd0, 5'd1, 5'd2, 5'd0, 5'd0, F_ADDU), 1'b1, 5'd0, 32'h00000014);
    dbg_addr = 5'd0; #1;
    check_eq("dbg_r0_after_rd0", dbg_data, 32'd0);

    // 5: back-to-back with dependencies; instr_valid stays high throughout
    acc_q.delete();
    issue(mk(6'd0, 5'd1,  5'd7, 5'd13, 5'd0, F_ADDU), 1'b1, 1'b1, 5'd13, 32'h0000000F, 1'b1);
    issue(mk(6'd0, 5'd13, 5'd7, 5'd14, 5'd0, F_SUBU), 1'b1, 1'b1, 5'd14, 32'h0000000A, 1'b1);
    issue(mk(6'd0, 5'd14, 5'd0, 5'd15, 5'd2, F_SLL),  1'b1, 1'b1, 5'd15, 32'h00000028, 1'b0);
    drain();
    exp_rf[13] = 32'h0000000F;
    exp_rf[14] = 32'h0000000A;
    exp_rf[15] = 32'h00000028;
    if (acc_q.size() == 3) begin
      check_eq("accept_gap_1", 32'(acc_q[1] - acc_q[0]), 32'd4);
      check_eq("accept_gap_2", 32'(acc_q[2] - acc_q[1]), 32'd4);
    end else begin
      check_eq("accept_count", 32'(acc_q.size()), 32'd3);
    end
    check_rf();

    // 6: reset during EXEC aborts the op
    issue(mk(6'd0, 5'd1, 5'd2, 5'd16, 5'd0, F_ADDU), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_instr_ready", 32'(instr_ready), 32'd1);
    check_eq("midrst_wb_valid",    32'(wb_valid),    32'd0);
    check_eq("midrst_alu_src1",    alu_src1,         32'd0);
    @(negedge clk);
    check_eq("midrst_wb_valid_2",  32'(wb_valid),    32'd0);
    for (int i = 0; i < 32; i++) exp_rf[i] = '0;
    check_rf();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("post_rst_ready", 32'(instr_ready), 32'd1);
    preload(5'd3, 32'h00000055);
    check_rf();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
